vga_sync_decoder: RTL and testbench

- Receive-side counterpart of the porch/sync generation path: consumes active-low VGA HSync/VSync (porches already included) plus the pixel clock.
- Recovers column/row position and an active-video qualifier, and verifies the timing against the configured frame geometry.
- Feeds capture/loopback logic and on-board self-test of the 640x480 / 25 MHz video output.

---
 rtl/vga_sync_decoder.sv | 145 ++++++++++++++
 tb/tb_vga_sync_decoder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// Recovers pixel position from active-low HSync/VSync and locks once the line
// and frame lengths match the configured geometry.
module vga_sync_decoder #(
  parameter int TOTAL_COLS   = 800,
  parameter int TOTAL_ROWS   = 525,
  parameter int ACTIVE_COLS  = 640,
  parameter int ACTIVE_ROWS  = 480,
  parameter int H_SYNC_W     = 96,
  parameter int H_BACK_PORCH = 48,
  parameter int V_SYNC_W     = 2,
  parameter int V_BACK_PORCH = 33
) (
  input  logic       i_Clk,
  input  logic       i_Rst_N,
  input  logic       i_HSync,
  input  logic       i_VSync,
  output logic       o_Active,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_Frame_Start,
  output logic       o_Locked
);

  localparam logic [10:0] H_START = 11'(H_SYNC_W + H_BACK_PORCH);
  localparam logic [10:0] H_END   = 11'(H_SYNC_W + H_BACK_PORCH + ACTIVE_COLS - 1);
  localparam logic [10:0] H_LAST  = 11'(TOTAL_COLS - 1);
  localparam logic [10:0] H_TMO   = 11'(2 * TOTAL_COLS - 1);
  localparam logic [9:0]  V_START = 10'(V_SYNC_W + V_BACK_PORCH);
  localparam logic [9:0]  V_END   = 10'(V_SYNC_W + V_BACK_PORCH + ACTIVE_ROWS - 1);
  localparam logic [9:0]  V_LAST  = 10'(TOTAL_ROWS - 1);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  state_t      state, state_nxt;
  logic        err, err_nxt;
  logic        hs_r, hs_rd, vs_r, vs_rd;
  logic        pend;
  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        h_fall, v_fall, frame_start;
  logic        line_ok, frame_ok, timeout;
  logic        h_win, v_win, act;
  logic        fs_d;

  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      hs_r  <= 1'b1;
      hs_rd <= 1'b1;
      vs_r  <= 1'b1;
      vs_rd <= 1'b1;
    end else begin
      hs_r  <= i_HSync;
      hs_rd <= hs_r;
      vs_r  <= i_VSync;
      vs_rd <= vs_r;
    end
  end

  assign h_fall      = hs_rd & ~hs_r;
  assign v_fall      = vs_rd & ~vs_r;
  // A VSync fall only marks a frame; the frame begins on the next line start.
  assign frame_start = h_fall & (pend | v_fall);

  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      h_cnt <= '0;
      v_cnt <= '0;
      pend  <= 1'b0;
    end else begin
      if (h_fall)               h_cnt <= '0;
      else if (h_cnt != '1)     h_cnt <= h_cnt + 11'd1;

      if (frame_start)                  v_cnt <= '0;
      else if (h_fall && v_cnt != '1)   v_cnt <= v_cnt + 10'd1;

      if (frame_start)  pend <= 1'b0;
      else if (v_fall)  pend <= 1'b1;
    end
  end

  assign line_ok  = (h_cnt == H_LAST);
  assign frame_ok = (v_cnt == V_LAST);
  assign timeout  = (h_cnt >= H_TMO) & ~h_fall;

  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      state <= SEARCH;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = err;
    case (state)
      SEARCH: begin
        if (frame_start) begin
          state_nxt = CHECK;
          err_nxt   = 1'b0;
        end
      end
      CHECK: begin
        if (frame_start) begin
          // The closing line of the trial frame counts toward the verdict.
          if (!err && line_ok && frame_ok) state_nxt = LOCKED;
          err_nxt = 1'b0;
        end else if (h_fall && !line_ok) begin
          err_nxt = 1'b1;
        end
      end
      LOCKED: begin
        if (h_fall && (!line_ok || (frame_start && !frame_ok))) state_nxt = SEARCH;
      end
      default: state_nxt = SEARCH;
    endcase
    if (timeout) state_nxt = SEARCH;
  end

  assign h_win = (h_cnt >= H_START) && (h_cnt <= H_END);
  assign v_win = (v_cnt >= V_START) && (v_cnt <= V_END);
  assign act   = (state == LOCKED) && h_win && v_win;

  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      o_Active      <= 1'b0;
      o_Col_Count   <= '0;
      o_Row_Count   <= '0;
      o_Locked      <= 1'b0;
      o_Frame_Start <= 1'b0;
      fs_d          <= 1'b0;
    end else begin
      o_Active      <= act;
      o_Col_Count   <= act ? 10'(h_cnt - H_START) : '0;
      o_Row_Count   <= act ? (v_cnt - V_START) : '0;
      o_Locked      <= (state == LOCKED);
      // Extra stage keeps the pulse aligned with the position outputs.
      fs_d          <= frame_start && (state == LOCKED);
      o_Frame_Start <= fs_d;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench: 800-clock lines with a 6-line frame so lock, loss and
// relock sequences fit in a short run.
module tb_vga_sync_decoder;

  localparam int TC = 800;
  localparam int TR = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hsync, vsync;
  logic       active, fstart, locked;
  logic [9:0] col, row;
  logic [22:0] outs;

  int cyc = 0;
  int gen_frame = -1;
  int fs_edge [0:15];
  int n_chk = 0;
  int n_pass = 0;

  vga_sync_decoder #(
    .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(640), .ACTIVE_ROWS(3),
    .H_SYNC_W(96), .H_BACK_PORCH(48), .V_SYNC_W(1), .V_BACK_PORCH(1)
  ) dut (
    .i_Clk(clk), .i_Rst_N(rst_n), .i_HSync(hsync), .i_VSync(vsync),
    .o_Active(active), .o_Col_Count(col), .o_Row_Count(row),
    .o_Frame_Start(fstart), .o_Locked(locked)
  );

  assign outs = {active, locked, fstart, col, row};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d (edge %0d)", tag, got, exp, cyc);
  endtask

  // Returns #1 after posedge number n.
  task automatic after_edge(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_frame(input int f);
    while (gen_frame < f) @(posedge clk);
  endtask

  task automatic gen_line(input int f, input int l, input int len);
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      if (c == 0 && l == 0) begin
        fs_edge[f] = cyc + 1;
        gen_frame  = f;
      end
      hsync = (c >= 96);
      vsync = (l != 0);
    end
  endtask

  // Frame 6 has one 801-clock line, frame 8 is one line short, frame 11
  // ends in an HSync-less stretch.
  initial begin
    int rows, len;
    hsync = 1'b1;
    vsync = 1'b1;
    for (int f = 0; f < 12; f++) begin
      rows = (f == 8) ? TR - 1 : (f == 11) ? 2 : TR;
      for (int l = 0; l < rows; l++) begin
        len = (f == 6 && l == 3) ? TC + 1 : (f == 11 && l == 1) ? 1800 : TC;
        gen_line(f, l, len);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=%0d exp=%0d", cyc, 0);
    $fatal(1, "bench timed out");
  end

  initial begin
    int s, e, x;
    rst_n = 1'b0;
    after_edge(500);  chk("rst_outs_a", int'(outs), 0);
    after_edge(1200); chk("rst_outs_b", int'(outs), 0);
    after_edge(1700); rst_n = 1'b1;

    wait_frame(1); s = fs_edge[1];
    after_edge(s + 2);    chk("search_fs_unlocked", int'(locked), 0);
    after_edge(s + 2400); chk("check_unlocked", int'(locked), 0);

    wait_frame(2); s = fs_edge[2];
    after_edge(s + 1); chk("lock_pre", int'(locked), 0);
    after_edge(s + 2); chk("lock_rise", int'(locked), 1);
    chk("lock_no_fs", int'(fstart), 0);
    e = s + 2 * TC;
    after_edge(e + 145); chk("act_pre", int'(active), 0);
    after_edge(e + 146); chk("act_rise", int'(active), 1);
    chk("col_first", int'(col), 0);
    chk("row_first", int'(row), 0);
    after_edge(e + 785); chk("col_last", int'(col), 639);
    chk("act_last", int'(active), 1);
    after_edge(e + 786); chk("act_fall", int'(active), 0);
    chk("col_idle", int'(col), 0);
    after_edge(e + TC + 246); chk("col_mid", int'(col), 100);
    chk("row_second", int'(row), 1);

    wait_frame(3); s = fs_edge[3];
    after_edge(s + 1); chk("fs_pre", int'(fstart), 0);
    after_edge(s + 2); chk("fs_pulse", int'(fstart), 1);
    after_edge(s + 3); chk("fs_post", int'(fstart), 0);
    e = s + 2 * TC;
    after_edge(e + 400); chk("act_before_rst", int'(active), 1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", int'(outs), 0);
    after_edge(e + 420); rst_n = 1'b1;

    wait_frame(4); s = fs_edge[4];
    after_edge(s + 2);    chk("relock_first_fs", int'(locked), 0);
    after_edge(s + 2000); chk("relock_check", int'(locked), 0);
    wait_frame(5); s = fs_edge[5];
    after_edge(s + 2); chk("relock_rise", int'(locked), 1);

    wait_frame(6); s = fs_edge[6];
    after_edge(s + 2); chk("fs_pulse_2", int'(fstart), 1);
    x = s + 3 * TC + TC + 1;
    after_edge(x + 1); chk("long_line_pre", int'(locked), 1);
    after_edge(x + 2); chk("long_line_drop", int'(locked), 0);

    wait_frame(7); s = fs_edge[7];
    after_edge(s + 2); chk("long_search_fs", int'(locked), 0);
    wait_frame(8); s = fs_edge[8];
    after_edge(s + 2); chk("long_relock", int'(locked), 1);

    wait_frame(9); s = fs_edge[9];
    after_edge(s + 1); chk("short_frame_pre", int'(locked), 1);
    after_edge(s + 2); chk("short_frame_drop", int'(locked), 0);

    wait_frame(10); s = fs_edge[10];
    after_edge(s + 2); chk("short_search_fs", int'(locked), 0);
    wait_frame(11); s = fs_edge[11];
    after_edge(s + 2); chk("short_relock", int'(locked), 1);
    e = s + TC;
    after_edge(e + 1601); chk("timeout_pre", int'(locked), 1);
    after_edge(e + 1602); chk("timeout_drop", int'(locked), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
